seg_display_ctrl: RTL and testbench
===================================

SEG_DISPLAY_CTRL -- requirements
Module: seg_display_ctrl

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 8, number of seven-segment digits driven (legal 1..8).
REQ-002 SHALL have parameter BLINK_DIV, default 25000000, clock cycles per blink half-period (legal >= 2).
REQ-003 SHALL have parameter ACTIVE_LOW, default 1, segment polarity (1: lit segment = 0).
REQ-004 clock  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 wr_en  input  1  write request; accepted on a rising edge where wr_en=1 and busy=0.
REQ-007 wr_data  input  32  unsigned value to display.
REQ-008 dec_mode  input  1  sampled with wr_en; 0 = hex display, 1 = unsigned decimal display.
REQ-009 blink_en  input  1  1 = blank all digits during blink-off phase.
REQ-010 busy  output  1  high while a decimal conversion is in progress.
REQ-011 seg  output  7*NUM_DIGITS  digit i at seg[7i+6:7i], bit order gfedcba (bit 0 = a).
REQ-012 disp_value  output  32  raw binary value currently committed to display.
REQ-013 leds  output  8  equals disp_value[7:0].

Function
REQ-014 SHALL implement FSM states IDLE and CONV; busy = (state == CONV).
REQ-015 Hex accept in IDLE: disp_value and digit register updated on the accepting edge; digit i = value[4i+3:4i]; state stays IDLE.
REQ-016 Decimal accept in IDLE: capture wr_data, enter CONV, run shift-add-3 binary-to-BCD over 32 iterations, one per cycle, into a 40-bit (10-digit) BCD register.
REQ-017 Decimal accepted at edge E0: busy high after E0 through E32; at E32 disp_value = captured value, digit register = low NUM_DIGITS BCD digits (value mod 10^NUM_DIGITS), state -> IDLE.
REQ-018 During CONV, display and disp_value SHALL hold previous contents unchanged.
REQ-019 wr_en while busy=1 SHALL be ignored, no queuing; wr_en on the E32 edge is also ignored (busy still 1 when sampled).
REQ-020 Digit decode: 0-9, A-F standard shapes (b,c,d,e,g for 'd'; lowercase b,d; uppercase A,C,E,F); blank = no segments lit.
REQ-021 ACTIVE_LOW=1: seg = inverted decode; blank = all ones. ACTIVE_LOW=0: non-inverted; blank = all zeros.
REQ-022 Blink counter SHALL run freely 0..BLINK_DIV-1, toggle phase on wrap, independent of blink_en and writes.
REQ-023 blink_en=1 and phase=1: every digit blank; otherwise normal decode; seg fully registered (one-cycle latency from digit register/phase).
REQ-024 Decimal digits are always 0-9; values above 10^NUM_DIGITS-1 silently truncate to low digits.

Reset
REQ-025 While reset high: state IDLE, busy 0, disp_value 0, digit register 0, BCD/shift registers 0, blink counter 0, phase 0.
REQ-026 Reset asserted mid-conversion SHALL abort it; no partial result committed; first write after reset release accepted normally.
REQ-027 After reset, seg shows value 0 per REQ-029 rules; leds = 0.

Configuration
REQ-028 Macro SEG_LZB_EN SHALL control leading-zero blanking.
REQ-029 SEG_LZB_EN defined: digits above the most significant non-zero digit are blank; digit 0 is always shown (value 0 shows single "0"). Undefined: all NUM_DIGITS digits shown, including leading zeros.

Verification
REQ-030 Hex: NUM_DIGITS=8, ACTIVE_LOW=1, write 0x1234ABCD dec_mode=0 -> disp_value=0x1234ABCD after edge, digits7..0 = 1,2,3,4,A,b,C,d; digit0 seg = 7'b0100001; leds=0xCD; busy never high.
REQ-031 Decimal: write 12345678 dec_mode=1 -> busy high exactly 32 cycles, then digits7..0 = 1..8; second write 0x55 during busy dropped, display stays 12345678.
REQ-032 Truncation: NUM_DIGITS=4, decimal write 4294967295 -> digits = 7,2,9,5; disp_value=0xFFFFFFFF.
REQ-033 LZB: SEG_LZB_EN defined, hex write 0x000000A0 -> digits7..2 all ones, digit1 'A', digit0 '0'; without macro digits7..2 show '0' (7'b1000000).
REQ-034 Blink: BLINK_DIV=4, blink_en=1 -> seg alternates 4 cycles normal / 4 cycles all ones; blink_en=0 -> never blanks.
REQ-035 Reset 10 cycles into a decimal conversion -> busy 0, disp_value 0 immediately; subsequent hex write 0x7 displays 7 one edge later.

Source files
------------

// File: rtl/seg_display_ctrl.sv
// Seven-segment display controller: hex or decimal (shift-add-3) display, blink, optional
// leading-zero blanking when SEG_LZB_EN is defined.
//
// state | meaning
// IDLE  | display stable, writes accepted
// CONV  | binary-to-BCD conversion running, writes ignored
module seg_display_ctrl #(
    parameter int NUM_DIGITS = 8,
    parameter int BLINK_DIV  = 25000000,
    parameter int ACTIVE_LOW = 1
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    wr_en,
    input  logic [31:0]             wr_data,
    input  logic                    dec_mode,
    input  logic                    blink_en,
    output logic                    busy,
    output logic [7*NUM_DIGITS-1:0] seg,
    output logic [31:0]             disp_value,
    output logic [7:0]              leds
);

    localparam int DW = 4 * NUM_DIGITS;
    localparam int BW = $clog2(BLINK_DIV);

    typedef enum logic {IDLE, CONV} state_t;

    function automatic logic [6:0] decode_digit(input logic [3:0] d);
        logic [6:0] p;
        case (d)
            4'h0: p = 7'h3F;
            4'h1: p = 7'h06;
            4'h2: p = 7'h5B;
            4'h3: p = 7'h4F;
            4'h4: p = 7'h66;
            4'h5: p = 7'h6D;
            4'h6: p = 7'h7D;
            4'h7: p = 7'h07;
            4'h8: p = 7'h7F;
            4'h9: p = 7'h6F;
            4'hA: p = 7'h77;
            4'hB: p = 7'h7C;
            4'hC: p = 7'h39;
            4'hD: p = 7'h5E;
            4'hE: p = 7'h79;
            default: p = 7'h71;
        endcase
        return p;
    endfunction

    // Pattern shown for a value of zero, used as the seg reset value.
    function automatic logic [7*NUM_DIGITS-1:0] zero_seg();
        logic [7*NUM_DIGITS-1:0] r;
        logic [6:0] p;
        r = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            p = 7'h3F;
`ifdef SEG_LZB_EN
            if (i != 0) p = 7'h00;
`endif
            if (ACTIVE_LOW != 0) p = ~p;
            r[7*i +: 7] = p;
        end
        return r;
    endfunction

    localparam logic [7*NUM_DIGITS-1:0] SEG_RESET = zero_seg();

    state_t                    state_q, state_d;
    logic                      load_conv, commit_hex, commit_dec;
    logic [31:0]               conv_value;
    logic [31:0]               shift_q;
    logic [39:0]               bcd_q, bcd_adj, bcd_step;
    logic [4:0]                iter_cnt;
    logic [DW-1:0]             digit_q;
    logic [BW-1:0]             blink_cnt;
    logic                      phase_q;
    logic [NUM_DIGITS-1:0]     lz_blank;
    logic [7*NUM_DIGITS-1:0]   seg_d;
    logic [6:0]                pat;

    assign busy = (state_q == CONV);
    assign leds = disp_value[7:0];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        load_conv  = 1'b0;
        commit_hex = 1'b0;
        commit_dec = 1'b0;
        case (state_q)
            IDLE: begin
                if (wr_en) begin
                    if (dec_mode) begin
                        load_conv = 1'b1;
                        state_d   = CONV;
                    end else begin
                        commit_hex = 1'b1;
                    end
                end
            end
            CONV: begin
                if (iter_cnt == 5'd0) begin
                    commit_dec = 1'b1;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // One shift-add-3 iteration: adjust every BCD digit >= 5, then shift in the next binary bit.
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < 10; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
        end
        bcd_step = (bcd_adj << 1) | {39'd0, shift_q[31]};
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            conv_value <= '0;
            shift_q    <= '0;
            bcd_q      <= '0;
            iter_cnt   <= '0;
            digit_q    <= '0;
            disp_value <= '0;
        end else begin
            if (load_conv) begin
                conv_value <= wr_data;
                shift_q    <= wr_data;
                bcd_q      <= '0;
                iter_cnt   <= 5'd31;
            end else if (state_q == CONV) begin
                shift_q <= shift_q << 1;
                bcd_q   <= bcd_step;
                if (iter_cnt != 5'd0) iter_cnt <= iter_cnt - 5'd1;
            end
            if (commit_hex) begin
                disp_value <= wr_data;
                digit_q    <= wr_data[DW-1:0];
            end else if (commit_dec) begin
                disp_value <= conv_value;
                digit_q    <= bcd_step[DW-1:0];
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            blink_cnt <= '0;
            phase_q   <= 1'b0;
        end else if (blink_cnt == BW'(BLINK_DIV - 1)) begin
            blink_cnt <= '0;
            phase_q   <= ~phase_q;
        end else begin
            blink_cnt <= blink_cnt + 1'b1;
        end
    end

`ifdef SEG_LZB_EN
    logic above_zero;
    always_comb begin
        lz_blank   = '0;
        above_zero = 1'b1;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            above_zero  = above_zero && (digit_q[4*i +: 4] == 4'd0);
            lz_blank[i] = above_zero;
        end
    end
`else
    assign lz_blank = '0;
`endif

    always_comb begin
        seg_d = '0;
        pat   = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            pat = decode_digit(digit_q[4*i +: 4]);
            if ((blink_en && phase_q) || lz_blank[i]) pat = 7'h00;
            if (ACTIVE_LOW != 0) pat = ~pat;
            seg_d[7*i +: 7] = pat;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) seg <= SEG_RESET;
        else       seg <= seg_d;
    end

endmodule

// File: tb/tb_seg_display_ctrl.sv
// Bench for seg_display_ctrl: an 8-digit active-low and a 4-digit active-high instance share
// stimulus; a value-level model is compared every cycle, plus literal spot checks.
module tb_seg_display_ctrl;

    logic        clock = 1'b0;
    logic        reset;
    logic        wr_en, dec_mode, blink_en;
    logic [31:0] wr_data;
    logic        busy8, busy4;
    logic [55:0] seg8;
    logic [27:0] seg4;
    logic [31:0] disp8, disp4;
    logic [7:0]  leds8, leds4;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_on   = 0;

    always #5 clock = ~clock;

    seg_display_ctrl #(.NUM_DIGITS(8), .BLINK_DIV(4), .ACTIVE_LOW(1)) dut8 (
        .clock(clock), .reset(reset), .wr_en(wr_en), .wr_data(wr_data),
        .dec_mode(dec_mode), .blink_en(blink_en), .busy(busy8), .seg(seg8),
        .disp_value(disp8), .leds(leds8));

    seg_display_ctrl #(.NUM_DIGITS(4), .BLINK_DIV(4), .ACTIVE_LOW(0)) dut4 (
        .clock(clock), .reset(reset), .wr_en(wr_en), .wr_data(wr_data),
        .dec_mode(dec_mode), .blink_en(blink_en), .busy(busy4), .seg(seg4),
        .disp_value(disp4), .leds(leds4));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
        end
    endtask

    function automatic logic [6:0] shape(input int d);
        case (d)
            0: return 7'h3F;  1: return 7'h06;  2: return 7'h5B;  3: return 7'h4F;
            4: return 7'h66;  5: return 7'h6D;  6: return 7'h7D;  7: return 7'h07;
            8: return 7'h7F;  9: return 7'h6F;  10: return 7'h77; 11: return 7'h7C;
            12: return 7'h39; 13: return 7'h5E; 14: return 7'h79; default: return 7'h71;
        endcase
    endfunction

    // Display pattern for value v, read as hex or decimal digits, truncated to nd digits.
    function automatic logic [55:0] model_seg(input int nd, input bit al, input logic [31:0] v,
                                              input bit dec, input bit blank_all);
        logic [55:0] r;
        logic [6:0]  p;
        longint      base, full, shown, place;
        bit          blank;
        r = '0;
        base = dec ? 10 : 16;
        full = 1;
        for (int i = 0; i < nd; i++) full = full * base;
        shown = longint'(v) % full;
        place = 1;
        for (int i = 0; i < nd; i++) begin
            blank = blank_all;
`ifdef SEG_LZB_EN
            if (i > 0 && shown < place) blank = 1;
`endif
            p = blank ? 7'h00 : shape(int'((shown / place) % base));
            if (al) p = ~p;
            r[7*i +: 7] = p;
            place = place * base;
        end
        return r;
    endfunction

    logic [31:0] m_val, m_pend;
    bit          m_dec;
    int          m_rem;
    longint      m_edges;
    logic [55:0] exp_seg8, exp_seg4;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_val = 0; m_pend = 0; m_dec = 0; m_rem = 0; m_edges = 0;
            exp_seg8 = model_seg(8, 1, 32'd0, 0, 0);
            exp_seg4 = model_seg(4, 0, 32'd0, 0, 0);
        end else begin
            exp_seg8 = model_seg(8, 1, m_val, m_dec, blink_en && ((m_edges / 4) % 2 == 1));
            exp_seg4 = model_seg(4, 0, m_val, m_dec, blink_en && ((m_edges / 4) % 2 == 1));
            m_edges++;
            if (m_rem > 0) begin
                m_rem--;
                if (m_rem == 0) begin
                    m_val = m_pend;
                    m_dec = 1;
                end
            end else if (wr_en) begin
                if (dec_mode) begin
                    m_pend = wr_data;
                    m_rem  = 32;
                end else begin
                    m_val = wr_data;
                    m_dec = 0;
                end
            end
        end
    end

    always @(posedge clock) begin
        #1;
        if (chk_on) begin
            chk("busy8", busy8, m_rem > 0);
            chk("busy4", busy4, m_rem > 0);
            chk("disp8", disp8, m_val);
            chk("disp4", disp4, m_val);
            chk("leds8", leds8, m_val[7:0]);
            chk("leds4", leds4, m_val[7:0]);
            chk("seg8", seg8, exp_seg8);
            chk("seg4", seg4, exp_seg4);
        end
    end

    task automatic write(input logic [31:0] data, input logic dec);
        @(negedge clock);
        wr_data  = data;
        dec_mode = dec;
        wr_en    = 1'b1;
        @(negedge clock);
        wr_en    = 1'b0;
    endtask

    int busy_cycles, blanks;

    initial begin
        reset = 1'b1; wr_en = 0; wr_data = 0; dec_mode = 0; blink_en = 0;
        @(negedge clock);
        chk_on = 1;
        @(negedge clock);
        reset = 1'b0;
        repeat (2) @(negedge clock);

`ifdef SEG_LZB_EN
        chk("rst_seg8", seg8, {{7{7'b1111111}}, 7'b1000000});
`else
        chk("rst_seg8", seg8, {8{7'b1000000}});
`endif
        chk("rst_disp8", disp8, 32'd0);
        chk("rst_leds8", leds8, 8'd0);

        write(32'h1234ABCD, 1'b0);
        chk("hex_disp", disp8, 32'h1234ABCD);
        chk("hex_leds", leds8, 8'hCD);
        chk("hex_busy", busy8, 1'b0);
        @(negedge clock);
        chk("hex_d0", seg8[6:0], 7'b0100001);
        chk("hex_seg8", seg8, {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                7'b0001000, 7'b0000011, 7'b1000110, 7'b0100001});

        write(32'd12345678, 1'b1);
        busy_cycles = 0;
        for (int k = 0; k < 40; k++) begin
            if (busy8) busy_cycles++;
            if (k == 1 || k == 31) begin
                wr_data = (k == 1) ? 32'h55 : 32'h99; dec_mode = 0; wr_en = 1;
            end else begin
                wr_en = 0;
            end
            @(negedge clock);
        end
        chk("dec_busy_cycles", busy_cycles, 32);
        chk("dec_disp", disp8, 32'd12345678);
        chk("dec_seg8", seg8, {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000});
        chk("dec_seg4", seg4, {7'b1101101, 7'b1111101, 7'b0000111, 7'b1111111});

        write(32'hFFFFFFFF, 1'b1);
        repeat (34) @(negedge clock);
        chk("trunc_disp4", disp4, 32'hFFFFFFFF);
        chk("trunc_seg4", seg4, {7'b0000111, 7'b1011011, 7'b1101111, 7'b1101101});

        write(32'h000000A0, 1'b0);
        @(negedge clock);
`ifdef SEG_LZB_EN
        chk("lzb_seg8", seg8, {{6{7'b1111111}}, 7'b0001000, 7'b1000000});
`else
        chk("lzb_seg8", seg8, {{6{7'b1000000}}, 7'b0001000, 7'b1000000});
`endif

        write(32'h1234ABCD, 1'b0);
        blink_en = 1'b1;
        @(negedge clock);
        blanks = 0;
        for (int k = 0; k < 16; k++) begin
            @(negedge clock);
            if (seg8 == {56{1'b1}}) blanks++;
            if (seg4 == 28'd0) blanks++;
        end
        chk("blink_on_blanks", blanks, 16);
        blink_en = 1'b0;
        @(negedge clock);
        blanks = 0;
        for (int k = 0; k < 16; k++) begin
            @(negedge clock);
            if (seg8 == {56{1'b1}}) blanks++;
        end
        chk("blink_off_blanks", blanks, 0);

        write(32'd999, 1'b1);
        repeat (9) @(negedge clock);
        chk("abort_busy_before", busy8, 1'b1);
        reset = 1'b1;
        #1;
        chk("abort_busy", busy8, 1'b0);
        chk("abort_disp8", disp8, 32'd0);
        chk("abort_disp4", disp4, 32'd0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        write(32'h7, 1'b0);
        chk("post_rst_disp", disp8, 32'h7);
        @(negedge clock);
`ifdef SEG_LZB_EN
        chk("post_rst_seg8", seg8, {{7{7'b1111111}}, 7'b1111000});
`else
        chk("post_rst_seg8", seg8, {{7{7'b1000000}}, 7'b1111000});
`endif
        repeat (3) @(negedge clock);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
